seven_seg_reader: RTL and testbench
===================================

# seven_seg_reader

Sampling decoder for a 7-bit active-low seven-segment bus, mapping segment patterns back to digit codes. It works in the opposite direction to our digit-to-segment encoder. Used for loopback self-check of the display path and for reading scanned display buses.
- A pattern is accepted only after it has been stable for a programmable number of sample strobes.
- On acceptance, the block reports the decoded code, whether it was recognised, and a one-cycle update pulse.

## Interface
- STABLE_CNT, 4: consecutive identical samples required before acceptance; legal range 1..255.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- segments  input  7  segment bus, low = segment ON; bit 0 = segment a … bit 6 = segment g.
- sample_en  input  1  sample strobe; `segments` is evaluated only in cycles where this is high.
- digit  output  4  accepted code: 0–9 for digits, 4'hA for dash, 4'hF for unrecognised.
- code_ok  output  1  accepted pattern is a digit or dash.
- locked  output  1  a pattern is currently accepted and still being sampled unchanged.
- update  output  1  one-cycle pulse on each acceptance.
- err_cnt  output  8  saturating count of accepted unrecognised patterns.

## Operation
- Decode table (segments → digit):
  - 7'b1000000→0, 7'b1111001→1, 7'b0100100→2, 7'b0110000→3, 7'b0011001→4
  - 7'b0010010→5, 7'b0000010→6, 7'b1111000→7, 7'b0000000→8, 7'b0011000→9
  - 7'b0111111→4'hA (dash)
  - anything else→4'hF, with code_ok=0
- Internal state:
  - cand: 7-bit candidate pattern, reset 7'h7F.
  - cnt: match counter of width $clog2(STABLE_CNT+1), reset 0; saturates at STABLE_CNT.
- FSM states: EMPTY (reset), SETTLING, LOCKED.
- EMPTY, on sample_en: cand←segments, cnt←1 → SETTLING.
  - If STABLE_CNT=1, the first sample is instead accepted directly → LOCKED.
- SETTLING, on sample_en:
  - segments==cand: cnt+1; if this reaches STABLE_CNT → accept, → LOCKED.
  - segments≠cand: cand←segments, cnt←1, stay in SETTLING (STABLE_CNT=1: accept immediately).
- LOCKED, on sample_en:
  - segments==cand: no change.
  - segments≠cand: cand←segments, cnt←1, locked←0 → SETTLING; digit, code_ok and err_cnt hold their previous values.
- Accept action, all outputs registered on the same edge:
  - digit and code_ok ← decode(cand at acceptance)
  - locked←1, update←1 for exactly one cycle
  - if code is 4'hF, err_cnt+1, saturating at 255
- Re-accepting the same pattern after a glitch still pulses update.
- sample_en low: all state and outputs hold; update returns to 0.

## Timing
- Reset values: digit=4'hF, code_ok=0, locked=0, update=0, err_cnt=0, state EMPTY.
- Reset takes effect immediately, including mid-settle or mid-pulse. On release, the first strobe is treated as in EMPTY.
- Latency: outputs change on the clock edge that samples the STABLE_CNT-th consecutive matching strobe and are visible the following cycle.
  - Minimum acceptance time: STABLE_CNT strobes.
  - Strobes need not be contiguous; cycles without sample_en neither reset nor advance cnt.
- update never asserts in two consecutive cycles unless STABLE_CNT=1 and the pattern differs on back-to-back strobes.
- A pattern change on the same strobe that would complete a count restarts counting; there is no acceptance on that strobe.

## Structure
- Shared include seven_seg_defs.vh, also used by the encoder, holds:
  - the 11 pattern localparams
  - DASH_CODE=4'hA and BAD_CODE=4'hF
- Sub-module seven_seg_pattern_decode: purely combinational; segments in → 4-bit code plus ok flag.
- Top level contains the FSM, counter, output registers and error counter.

## Test plan
- STABLE_CNT=4: hold 7'b0100100 for 4 strobes → update pulse one cycle after the 4th strobe; digit=2, code_ok=1, locked=1; no update after only 3 strobes.
- Locked on 5, then segments=7'b1111001 for 2 strobes, 7'b0010010 for 1, 7'b1111001 for 4 → locked falls on the first change, digit stays 5 throughout, single update with digit=1 after the final run.
- Hold 7'b1010101 for 4 strobes → digit=4'hF, code_ok=0, err_cnt=1. Repeat 300 acceptances → err_cnt saturates at 255.
- Dash 7'b0111111 → digit=4'hA, code_ok=1. Strobes spread with 3 idle cycles between each → acceptance still occurs after 4 strobes.
- Assert rst two cycles into settling and during an update pulse → outputs take their reset values asynchronously. STABLE_CNT=1 → every strobe with a new pattern produces an update.

Source files
------------

// File: rtl/seven_seg_reader_pkg.sv
// Shared definitions for the seven-segment reader: segment patterns, special codes,
// FSM state type and the decoder result payload.
package seven_seg_reader_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned ERR_W  = 8;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [CODE_W-1:0] DASH_CODE = 4'hA;
    localparam logic [CODE_W-1:0] BAD_CODE  = 4'hF;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              ok;
    } decode_t;

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational segment-pattern to digit-code lookup; unknown patterns map to BAD_CODE.
module seven_seg_pattern_decode
    import seven_seg_reader_pkg::*;
(
    input  logic [SEG_W-1:0] segments,
    output decode_t          result_c
);

    always_comb begin
        result_c.code = BAD_CODE;
        result_c.ok   = 1'b1;
        case (segments)
            SEG_0:    result_c.code = 4'd0;
            SEG_1:    result_c.code = 4'd1;
            SEG_2:    result_c.code = 4'd2;
            SEG_3:    result_c.code = 4'd3;
            SEG_4:    result_c.code = 4'd4;
            SEG_5:    result_c.code = 4'd5;
            SEG_6:    result_c.code = 4'd6;
            SEG_7:    result_c.code = 4'd7;
            SEG_8:    result_c.code = 4'd8;
            SEG_9:    result_c.code = 4'd9;
            SEG_DASH: result_c.code = DASH_CODE;
            default: begin
                result_c.code = BAD_CODE;
                result_c.ok   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Sampling seven-segment decoder: accepts a pattern once it has been seen on
// STABLE_CNT consecutive strobes and reports its code with a one-cycle update pulse.
module seven_seg_reader
    import seven_seg_reader_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEG_W-1:0]  segments,
    input  logic              sample_en,
    output logic [CODE_W-1:0] digit,
    output logic              code_ok,
    output logic              locked,
    output logic              update,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t            state_q, state_d;
    logic [SEG_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] digit_q, digit_d;
    logic              code_ok_q, code_ok_d;
    logic              update_q, update_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              match_c;
    decode_t           dec_c;

    // Decoding the live bus is equivalent to decoding cand on any accepting strobe
    seven_seg_pattern_decode u_decode (
        .segments (segments),
        .result_c (dec_c)
    );

    assign match_c = (state_q != EMPTY) && (segments == cand_q);

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        code_ok_d = code_ok_q;
        update_d  = 1'b0;
        err_d     = err_q;
        // A matching strobe while locked changes nothing; every other strobe advances or restarts
        if (sample_en && !(state_q == LOCKED && match_c)) begin
            if (match_c) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cand_d = segments;
                cnt_d  = CNT_ONE;
            end
            if (cnt_d == CNT_DONE) begin
                state_d   = LOCKED;
                digit_d   = dec_c.code;
                code_ok_d = dec_c.ok;
                update_d  = 1'b1;
                if (dec_c.code == BAD_CODE && err_q != ERR_MAX) begin
                    err_d = err_q + ERR_W'(1);
                end
            end else begin
                state_d = SETTLING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            cand_q    <= SEG_BLANK;
            cnt_q     <= '0;
            digit_q   <= BAD_CODE;
            code_ok_q <= 1'b0;
            update_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            code_ok_q <= code_ok_d;
            update_q  <= update_d;
            err_q     <= err_d;
        end
    end

    assign digit   = digit_q;
    assign code_ok = code_ok_q;
    assign locked  = (state_q == LOCKED);
    assign update  = update_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: two instances (STABLE_CNT=4 and 1) checked every cycle
// against a run-length reference model, plus directed literal checks.
module tb_seven_seg_reader;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000, P5 = 7'b0010010, P7 = 7'b1111000;
    localparam logic [6:0] PD = 7'b0111111, BAD_A = 7'b1010101, BAD_B = 7'b1010110;
    localparam logic [6:0] PATS [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0011000, 7'b0111111};
    localparam int NS [2] = '{4, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] segments = 7'h7F;
    logic       sample_en = 1'b0;

    logic [3:0] digit0, digit1;
    logic       code_ok0, code_ok1, locked0, locked1, update0, update1;
    logic [7:0] err0, err1;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // Reference model state: length of the current run of identical strobes per instance
    int         m_run   [2];
    logic [6:0] m_last  [2];
    logic [3:0] m_digit [2];
    logic       m_ok    [2];
    logic       m_upd   [2];
    int         m_err   [2];

    always #5 clk = ~clk;

    seven_seg_reader #(.STABLE_CNT(4)) u_dut4 (
        .clk(clk), .rst(rst), .segments(segments), .sample_en(sample_en),
        .digit(digit0), .code_ok(code_ok0), .locked(locked0), .update(update0), .err_cnt(err0)
    );

    seven_seg_reader #(.STABLE_CNT(1)) u_dut1 (
        .clk(clk), .rst(rst), .segments(segments), .sample_en(sample_en),
        .digit(digit1), .code_ok(code_ok1), .locked(locked1), .update(update1), .err_cnt(err1)
    );

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return {4'd0, 1'b1};
            7'b1111001: return {4'd1, 1'b1};
            7'b0100100: return {4'd2, 1'b1};
            7'b0110000: return {4'd3, 1'b1};
            7'b0011001: return {4'd4, 1'b1};
            7'b0010010: return {4'd5, 1'b1};
            7'b0000010: return {4'd6, 1'b1};
            7'b1111000: return {4'd7, 1'b1};
            7'b0000000: return {4'd8, 1'b1};
            7'b0011000: return {4'd9, 1'b1};
            7'b0111111: return {4'hA, 1'b1};
            default:    return {4'hF, 1'b0};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Acceptance happens on the strobe that makes the run exactly STABLE_CNT long
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]   <= 0;
                m_last[i]  <= 7'h7F;
                m_digit[i] <= 4'hF;
                m_ok[i]    <= 1'b0;
                m_upd[i]   <= 1'b0;
                m_err[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int         run  = m_run[i];
                automatic logic [6:0] last = m_last[i];
                automatic logic [4:0] dec;
                automatic logic       upd  = 1'b0;
                if (sample_en) begin
                    if (run > 0 && segments == last) begin
                        if (run <= NS[i]) run++;
                    end else begin
                        run  = 1;
                        last = segments;
                    end
                    if (run == NS[i]) begin
                        dec = ref_decode(last);
                        m_digit[i] <= dec[4:1];
                        m_ok[i]    <= dec[0];
                        upd = 1'b1;
                        if (!dec[0] && m_err[i] < 255) m_err[i] <= m_err[i] + 1;
                    end
                end
                m_run[i]  <= run;
                m_last[i] <= last;
                m_upd[i]  <= upd;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("digit4",   32'(digit0),   32'(m_digit[0]));
            check("code_ok4", 32'(code_ok0), 32'(m_ok[0]));
            check("update4",  32'(update0),  32'(m_upd[0]));
            check("locked4",  32'(locked0),  32'(m_run[0] >= NS[0]));
            check("err4",     32'(err0),     32'(m_err[0]));
            check("digit1",   32'(digit1),   32'(m_digit[1]));
            check("code_ok1", 32'(code_ok1), 32'(m_ok[1]));
            check("update1",  32'(update1),  32'(m_upd[1]));
            check("locked1",  32'(locked1),  32'(m_run[1] >= NS[1]));
            check("err1",     32'(err1),     32'(m_err[1]));
        end
    end

    task automatic cyc(input logic [6:0] s, input logic en);
        @(negedge clk);
        #2;
        segments  = s;
        sample_en = en;
    endtask

    initial begin
        logic [6:0] p;
        int         len;

        repeat (3) cyc(7'h7F, 1'b0);
        check("rst_digit", 32'(digit0), 32'hF);
        check("rst_locked", 32'(locked0), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Digit 2 needs four strobes
        repeat (3) cyc(P2, 1'b1);
        cyc(P2, 1'b0);
        check("three_strobes_no_update", 32'(update0), 32'h0);
        cyc(P2, 1'b1);
        cyc(P2, 1'b0);
        check("accept2_update", 32'(update0), 32'h1);
        check("accept2_digit", 32'(digit0), 32'h2);
        check("accept2_ok", 32'(code_ok0), 32'h1);
        check("accept2_locked", 32'(locked0), 32'h1);
        cyc(P2, 1'b0);
        check("accept2_pulse_end", 32'(update0), 32'h0);

        // Locked on 5, glitchy change to 1
        repeat (4) cyc(P5, 1'b1);
        cyc(P5, 1'b0);
        check("lock5_digit", 32'(digit0), 32'h5);
        cyc(P1, 1'b1);
        cyc(P1, 1'b0);
        check("unlock_on_change", 32'(locked0), 32'h0);
        check("digit_holds5", 32'(digit0), 32'h5);
        cyc(P1, 1'b1);
        cyc(P5, 1'b1);
        repeat (3) cyc(P1, 1'b1);
        cyc(P1, 1'b0);
        check("glitch_restart", 32'(update0), 32'h0);
        check("glitch_digit5", 32'(digit0), 32'h5);
        cyc(P1, 1'b1);
        cyc(P1, 1'b0);
        check("accept1_update", 32'(update0), 32'h1);
        check("accept1_digit", 32'(digit0), 32'h1);

        // Unrecognised pattern
        repeat (4) cyc(BAD_A, 1'b1);
        cyc(BAD_A, 1'b0);
        check("bad_digit", 32'(digit0), 32'hF);
        check("bad_ok", 32'(code_ok0), 32'h0);
        check("bad_err", 32'(err0), 32'h1);

        // Dash with idle cycles between strobes
        for (int i = 0; i < 4; i++) begin
            cyc(PD, 1'b1);
            if (i < 3) repeat (3) cyc(PD, 1'b0);
        end
        cyc(PD, 1'b0);
        check("dash_update", 32'(update0), 32'h1);
        check("dash_digit", 32'(digit0), 32'hA);
        check("dash_ok", 32'(code_ok0), 32'h1);

        // Asynchronous reset mid-settle
        cyc(P3, 1'b1);
        cyc(P3, 1'b1);
        cyc(P3, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_settle_digit", 32'(digit0), 32'hF);
        check("arst_settle_ok", 32'(code_ok0), 32'h0);
        check("arst_settle_err", 32'(err0), 32'h0);
        cyc(7'h7F, 1'b0);
        rst = 1'b0;

        // Asynchronous reset during the update pulse
        repeat (4) cyc(P7, 1'b1);
        cyc(P7, 1'b0);
        check("pre_arst_update", 32'(update0), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_pulse_update", 32'(update0), 32'h0);
        check("arst_pulse_locked", 32'(locked0), 32'h0);
        check("arst_pulse_digit", 32'(digit0), 32'hF);
        cyc(7'h7F, 1'b0);
        rst = 1'b0;

        // STABLE_CNT=1: back-to-back new patterns each produce an update
        cyc(P0, 1'b1);
        cyc(P1, 1'b1);
        check("n1_first_update", 32'(update1), 32'h1);
        check("n1_first_digit", 32'(digit1), 32'h0);
        cyc(P1, 1'b0);
        check("n1_second_update", 32'(update1), 32'h1);
        check("n1_second_digit", 32'(digit1), 32'h1);
        cyc(P1, 1'b0);
        check("n1_pulse_end", 32'(update1), 32'h0);

        // Randomized runs with sparse strobes and occasional reset
        for (int k = 0; k < 350; k++) begin
            if ($urandom_range(0, 3) == 0) p = 7'($urandom);
            else p = PATS[$urandom_range(0, 10)];
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) cyc(p, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) begin
                cyc(p, 1'b0);
                rst = 1'b1;
                cyc(p, 1'b0);
                rst = 1'b0;
            end
        end

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            p = k[0] ? BAD_A : BAD_B;
            repeat (4) cyc(p, 1'b1);
        end
        cyc(p, 1'b0);
        cyc(p, 1'b0);
        check("err4_saturated", 32'(err0), 32'd255);
        check("err1_saturated", 32'(err1), 32'd255);

        repeat (2) cyc(p, 1'b0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
